// File: rtl/uart2wb_pkg.sv
// Shared constants for the UART-to-Wishbone debug master: command/reply bytes and FSM states.
package uart2wb_pkg;

  localparam logic [7:0] CMD_RD  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_WR  = 8'h77;  // 'w'
  localparam logic [7:0] RSP_OK  = 8'h6B;  // 'k'
  localparam logic [7:0] RSP_BAD = 8'h3F;  // '?'
  localparam logic [7:0] RSP_TO  = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_SEND
  } state_e;

endpackage

// File: rtl/uart2wb_ser.sv
// MSB-first reply serializer (1 or 4 bytes) owning the tx_wr/tx_busy handshake.
module uart2wb_ser (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_i,
  input  logic [31:0] ld_word_i,
  input  logic [2:0]  ld_cnt_i,
  input  logic        tx_busy_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_wr_o,
  output logic        busy_o
);

  logic [31:0] sh_q, sh_d;
  logic [2:0]  rem_q, rem_d;
  logic [7:0]  dat_q, dat_d;
  logic        wr_q, wr_d;

  // wr_q blocks a second strobe in the cycle where tx_busy may not yet reflect the first
  always_comb begin
    sh_d  = sh_q;
    rem_d = rem_q;
    dat_d = dat_q;
    wr_d  = 1'b0;
    if (ld_i) begin
      sh_d  = (ld_cnt_i == 3'd1) ? {ld_word_i[7:0], 24'd0} : ld_word_i;
      rem_d = ld_cnt_i;
    end else if (rem_q != 3'd0 && !wr_q && !tx_busy_i) begin
      dat_d = sh_q[31:24];
      wr_d  = 1'b1;
      sh_d  = {sh_q[23:0], 8'd0};
      rem_d = rem_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      rem_q <= '0;
      dat_q <= '0;
      wr_q  <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      rem_q <= rem_d;
      dat_q <= dat_d;
      wr_q  <= wr_d;
    end
  end

  assign tx_data_o = dat_q;
  assign tx_wr_o   = wr_q;
  assign busy_o    = (rem_q != 3'd0) || wr_q;

endmodule

// File: rtl/uart2wb.sv
// UART command decoder driving one 32-bit Wishbone transaction per command.
// Optional ack timeout enabled by defining UART2WB_TIMEOUT_EN.
module uart2wb
  import uart2wb_pkg::*;
#(
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  output logic        rx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        cyc_q, cyc_d;
  logic        rx_ack_q, rx_ack_d;
  logic        rx_take;
  logic        ld;
  logic [31:0] ld_word;
  logic [2:0]  ld_cnt;
  logic        ser_busy;
  logic        to_hit;

`ifdef UART2WB_TIMEOUT_EN
  localparam int unsigned TO_W = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(timeout_cycles - 1);
  logic [TO_W-1:0] to_q, to_d;

  // Counts BUS cycles from 0; leaving BUS on the last one gives exactly timeout_cycles of cyc
  assign to_d   = (state_q == S_BUS) ? to_q + TO_W'(1) : '0;
  assign to_hit = (to_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) to_q <= '0;
    else       to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    rx_ack_d = 1'b0;
    ld       = 1'b0;
    ld_word  = '0;
    ld_cnt   = 3'd0;
    rx_take  = rx_avail && !rx_ack_q;
    case (state_q)
      S_IDLE: if (rx_take) begin
        rx_ack_d = 1'b1;
        cnt_d    = 2'd0;
        if (rx_data == CMD_RD) begin
          we_d    = 1'b0;
          state_d = S_ADDR;
        end else if (rx_data == CMD_WR) begin
          we_d    = 1'b1;
          state_d = S_ADDR;
        end else begin
          ld      = 1'b1;
          ld_word = {24'd0, RSP_BAD};
          ld_cnt  = 3'd1;
          state_d = S_SEND;
        end
      end
      S_ADDR: if (rx_take) begin
        rx_ack_d = 1'b1;
        addr_d   = {addr_q[23:0], rx_data};
        cnt_d    = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (we_q) begin
            state_d = S_DATA;
          end else begin
            state_d = S_BUS;
            cyc_d   = 1'b1;
          end
        end
      end
      S_DATA: if (rx_take) begin
        rx_ack_d = 1'b1;
        data_d   = {data_q[23:0], rx_data};
        cnt_d    = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = S_BUS;
          cyc_d   = 1'b1;
        end
      end
      S_BUS: if (wb_ack_i) begin
        cyc_d   = 1'b0;
        ld      = 1'b1;
        ld_word = we_q ? {24'd0, RSP_OK} : wb_dat_i;
        ld_cnt  = we_q ? 3'd1 : 3'd4;
        state_d = S_SEND;
      end else if (to_hit) begin
        cyc_d   = 1'b0;
        ld      = 1'b1;
        ld_word = {24'd0, RSP_TO};
        ld_cnt  = 3'd1;
        state_d = S_SEND;
      end
      S_SEND: if (!ser_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      cyc_q    <= 1'b0;
      rx_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_d;
      rx_ack_q <= rx_ack_d;
    end
  end

  // Bus outputs are gated by cyc so they read as zero outside a transaction
  assign rx_ack   = rx_ack_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = cyc_q & we_q;
  assign wb_sel_o = {4{cyc_q}};
  assign wb_adr_o = cyc_q ? {addr_q[31:2], 2'b00} : '0;
  assign wb_dat_o = (cyc_q && we_q) ? data_q : '0;

  uart2wb_ser u_ser (
    .clk       (clk),
    .reset     (reset),
    .ld_i      (ld),
    .ld_word_i (ld_word),
    .ld_cnt_i  (ld_cnt),
    .tx_busy_i (tx_busy),
    .tx_data_o (tx_data),
    .tx_wr_o   (tx_wr),
    .busy_o    (ser_busy)
  );

endmodule

// File: tb/tb_uart2wb.sv
// Directed bench for uart2wb: read, write, unknown command, backpressure, reset, optional timeout.
module tb_uart2wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_avail;
  logic        rx_ack;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;

  always #5 clk = ~clk;

  uart2wb #(.timeout_cycles(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  // Slave model: ack after ack_dly extra cycles of cyc; ack_force injects a stray ack
  logic [31:0] rd_data;
  int          ack_dly;
  logic        ack_en, ack_force;
  int          wcnt = 0;
  assign wb_ack_i = ack_force | (ack_en & wb_cyc_o & (wcnt == ack_dly));
  assign wb_dat_i = rd_data;

  int          n_rxack = 0, n_tx = 0, bus_cnt = 0, cyc_hi = 0, unstable = 0, wr_busy = 0;
  logic [7:0]  tx_log [0:255];
  logic [31:0] l_adr, l_dat;
  logic        l_we;
  logic [3:0]  l_sel;
  logic        p_cyc = 1'b0, p_ack = 1'b0;
  logic [68:0] p_bus = '0;
  wire  [68:0] bus_now = {wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o};

  always @(posedge clk) begin
    wcnt <= (wb_cyc_o && !wb_ack_i) ? wcnt + 1 : 0;
    if (rx_ack) n_rxack <= n_rxack + 1;
    if (tx_wr) begin
      tx_log[n_tx[7:0]] <= tx_data;
      n_tx <= n_tx + 1;
    end
    if (tx_wr && tx_busy) wr_busy <= wr_busy + 1;
    if (wb_cyc_o) cyc_hi <= cyc_hi + 1;
    if (wb_cyc_o && wb_ack_i) begin
      bus_cnt <= bus_cnt + 1;
      l_adr   <= wb_adr_o;
      l_dat   <= wb_dat_o;
      l_we    <= wb_we_o;
      l_sel   <= wb_sel_o;
    end
    if ((wb_stb_o !== wb_cyc_o) || (wb_cyc_o && p_cyc && !p_ack && bus_now != p_bus))
      unstable <= unstable + 1;
    p_cyc <= wb_cyc_o;
    p_ack <= wb_ack_i;
    p_bus <= bus_now;
  end

  int nchk = 0, nerr = 0;
  int b_tx, b_bus, b_cyc, b_rx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    @(negedge clk);
    rx_data  = b;
    rx_avail = 1'b1;
    while (!rx_ack && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("rx_ack_seen", {31'd0, rx_ack}, 32'd1);
    rx_avail = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_tx(input string tag, input int base, input int n);
    int k;
    k = 0;
    while (n_tx - base < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    tick(4);
    chk(tag, n_tx - base, n);
  endtask

  function automatic logic [31:0] tx_word(input int b);
    logic [7:0] i;
    i = b[7:0];
    return {tx_log[i], tx_log[i + 8'd1], tx_log[i + 8'd2], tx_log[i + 8'd3]};
  endfunction

  task automatic snap();
    b_tx = n_tx; b_bus = bus_cnt; b_cyc = cyc_hi; b_rx = n_rxack;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ctl"}, {24'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, rx_ack}, 32'd0);
    chk({tag, "_adr"}, wb_adr_o, 32'd0);
    chk({tag, "_dat"}, wb_dat_o, 32'd0);
    chk({tag, "_tx"}, {23'd0, tx_wr, tx_data}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rx_avail = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    rd_data = 32'h0; ack_dly = 0; ack_en = 1'b1; ack_force = 1'b0;
    tick(3);
    chk_outs_zero("reset");
    reset = 1'b0;
    tick(2);

    // Read, zero-wait slave
    snap(); rd_data = 32'hDEADBEEF;
    send_byte(8'h72); send_word(32'h00001004);
    wait_tx("rd_txcnt", b_tx, 4);
    chk("rd_buscnt", bus_cnt - b_bus, 1);
    chk("rd_cyc_len", cyc_hi - b_cyc, 1);
    chk("rd_adr", l_adr, 32'h00001004);
    chk("rd_we", {31'd0, l_we}, 0);
    chk("rd_sel", {28'd0, l_sel}, 32'hF);
    chk("rd_data", tx_word(b_tx), 32'hDEADBEEF);
    chk("rd_rxack", n_rxack - b_rx, 5);

    // Unaligned address is forced to a word boundary
    snap(); rd_data = 32'h0BADF00D;
    send_byte(8'h72); send_word(32'h00001007);
    wait_tx("al_txcnt", b_tx, 4);
    chk("al_adr", l_adr, 32'h00001004);
    chk("al_data", tx_word(b_tx), 32'h0BADF00D);

    // Write, with a stray ack injected while collecting the address
    snap();
    send_byte(8'h77); send_byte(8'h00);
    ack_force = 1'b1; tick(3); ack_force = 1'b0;
    send_byte(8'h00); send_byte(8'h20); send_byte(8'h00);
    send_word(32'h12345678);
    wait_tx("wr_txcnt", b_tx, 1);
    chk("wr_buscnt", bus_cnt - b_bus, 1);
    chk("wr_adr", l_adr, 32'h00002000);
    chk("wr_dat", l_dat, 32'h12345678);
    chk("wr_we", {31'd0, l_we}, 1);
    chk("wr_sel", {28'd0, l_sel}, 32'hF);
    chk("wr_reply", {24'd0, tx_log[b_tx[7:0]]}, 32'h6B);

    // Unknown command, then a normal read
    snap();
    send_byte(8'h67);
    wait_tx("unk_txcnt", b_tx, 1);
    chk("unk_reply", {24'd0, tx_log[b_tx[7:0]]}, 32'h3F);
    chk("unk_cyc", cyc_hi - b_cyc, 0);
    snap(); rd_data = 32'hCAFEF00D;
    send_byte(8'h72); send_word(32'h00000008);
    wait_tx("unk_rd_txcnt", b_tx, 4);
    chk("unk_rd_adr", l_adr, 32'h00000008);
    chk("unk_rd_data", tx_word(b_tx), 32'hCAFEF00D);

    // Backpressure: slow slave, busy transmitter, early next command byte
    snap(); rd_data = 32'h01234567; ack_dly = 7; tx_busy = 1'b1;
    send_byte(8'h72); send_word(32'h00003000);
    rx_data = 8'h72; rx_avail = 1'b1;
    b_rx = n_rxack + 1;
    tick(500);
    chk("bp_rx_pending", n_rxack - b_rx, 0);
    chk("bp_no_tx", n_tx - b_tx, 0);
    chk("bp_buscnt", bus_cnt - b_bus, 1);
    chk("bp_cyc_len", cyc_hi - b_cyc, 8);
    chk("bp_adr", l_adr, 32'h00003000);
    tx_busy = 1'b0;
    for (int k = 0; k < 2000 && !rx_ack; k++) @(negedge clk);
    chk("bp_late_ack", {31'd0, rx_ack}, 1);
    chk("bp_tx_before_ack", n_tx - b_tx, 4);
    rx_avail = 1'b0;
    chk("bp_data", tx_word(b_tx), 32'h01234567);
    snap(); rd_data = 32'h89ABCDEF;
    send_word(32'h0000000C);
    wait_tx("bp2_txcnt", b_tx, 4);
    chk("bp2_adr", l_adr, 32'h0000000C);
    chk("bp2_data", tx_word(b_tx), 32'h89ABCDEF);
    ack_dly = 0;

    // Reset during BUS
    ack_en = 1'b0;
    send_byte(8'h72); send_word(32'h00006000);
    tick(3);
    chk("hang_cyc", {31'd0, wb_cyc_o}, 1);
    reset = 1'b1; tick(1);
    chk_outs_zero("rst_bus");
    reset = 1'b0; ack_en = 1'b1;

    // Reset mid-address, then a full write must not see stale bytes
    send_byte(8'h72); send_byte(8'h00); send_byte(8'h11);
    reset = 1'b1; tick(1);
    chk_outs_zero("rst_addr");
    reset = 1'b0; tick(1);
    snap();
    send_byte(8'h77); send_word(32'h00004000); send_word(32'hAABBCCDD);
    wait_tx("rst_wr_txcnt", b_tx, 1);
    chk("rst_wr_buscnt", bus_cnt - b_bus, 1);
    chk("rst_wr_adr", l_adr, 32'h00004000);
    chk("rst_wr_dat", l_dat, 32'hAABBCCDD);
    chk("rst_wr_reply", {24'd0, tx_log[b_tx[7:0]]}, 32'h6B);

`ifdef UART2WB_TIMEOUT_EN
    snap(); ack_en = 1'b0;
    send_byte(8'h72); send_word(32'h00005000);
    wait_tx("to_txcnt", b_tx, 1);
    chk("to_cyc_len", cyc_hi - b_cyc, 16);
    chk("to_reply", {24'd0, tx_log[b_tx[7:0]]}, 32'h45);
    snap(); ack_en = 1'b1; ack_dly = 15; rd_data = 32'h5A5AA5A5;
    send_byte(8'h72); send_word(32'h00005004);
    wait_tx("to_edge_txcnt", b_tx, 4);
    chk("to_edge_cyc_len", cyc_hi - b_cyc, 16);
    chk("to_edge_data", tx_word(b_tx), 32'h5A5AA5A5);
    ack_dly = 0;
`endif

    chk("wr_while_busy", wr_busy, 0);
    chk("bus_unstable", unstable, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
